// File: rtl/uart_rx_word_fifo_if.sv
// Byte-in / word-out handshake between the UART receiver, the word FIFO and its consumer.
interface uart_rx_word_fifo_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pop;
  logic [31:0] word_data;
  logic        word_valid;

  modport master (output rx_data, rx_valid, pop, input word_data, word_valid);
  modport slave  (input rx_data, rx_valid, pop, output word_data, word_valid);
endinterface

// File: rtl/uart_rx_word_fifo.sv
// Packs received UART bytes into 32-bit words and queues them in a show-ahead FIFO;
// a stalled partial word is thrown away after TIMEOUT_CYCLES idle cycles.
module uart_rx_word_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  flush,
  uart_rx_word_fifo_if.slave    bus,
  output logic [DEPTH_LOG2:0]   count,
  output logic [1:0]            byte_cnt,
  output logic                  overflow,
  output logic                  timeout_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // idle only needs to count 0..TIMEOUT_CYCLES-1; expiry fires on the last value
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH-1:0][31:0]  mem;
  logic [DEPTH_LOG2-1:0]   rd_ptr, wr_ptr;
  logic [31:0]             asm_word, full_word;
  logic [IW-1:0]           idle;
  logic [1:0]              lane;
  logic                    word_done, pop_ok, full, push, expire;

  always_comb begin
    lane      = MSB_FIRST ? (2'd3 - byte_cnt) : byte_cnt;
    full_word = asm_word;
    full_word[{lane, 3'b000} +: 8] = bus.rx_data;
    word_done = bus.rx_valid & (byte_cnt == 2'd3) & ~flush;
    pop_ok    = bus.pop & (count != '0) & ~flush;
    full      = (count == FULL_CNT);
    push      = word_done & (~full | pop_ok);
    expire    = (TIMEOUT_CYCLES > 0) && !bus.rx_valid && (byte_cnt != 2'd0) && (idle == IDLE_LAST);
  end

  assign bus.word_valid = (count != '0);
  assign bus.word_data  = bus.word_valid ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      byte_cnt    <= 2'd0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      idle        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      asm_word    <= 32'h0;
    end else if (flush) begin
      count       <= '0;
      byte_cnt    <= 2'd0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      idle        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (bus.rx_valid) begin
        asm_word <= full_word;
        byte_cnt <= byte_cnt + 2'd1;
      end else if (expire) begin
        byte_cnt    <= 2'd0;
        timeout_err <= 1'b1;
      end
      if (bus.rx_valid || byte_cnt == 2'd0 || expire) idle <= '0;
      else                                            idle <= idle + 1'b1;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (word_done && full && !pop_ok) overflow <= 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: word_data is gated by count
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= full_word;
  end
endmodule
